dmg_timer: RTL and testbench

- Programmable timer: TIMA (FF05), TMA (FF06) and TAC (FF07).
- Sits directly downstream of the clock/divider block. It consumes the divider frequency taps and drives the CPU data bus on reads.
- Raises a one-cycle timer interrupt request toward the interrupt-flag logic when TIMA overflows.
- clk is the 1 MHz machine-cycle clock (boga1mhz).

---
 rtl/dmg_timer_pkg.sv | 33 +++
 rtl/dmg_timer_tick.sv | 52 +++++
 rtl/dmg_timer.sv | 131 +++++++++++++
 tb/tb_dmg_timer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmg_timer_pkg.sv
// Shared constants for the DMG programmable timer (TIMA/TMA/TAC).
// Tap selection helper is shared by both edge-detection variants of the tick block.
package dmg_timer_pkg;

    localparam logic [1:0] CS_4096   = 2'b00;
    localparam logic [1:0] CS_262144 = 2'b01;
    localparam logic [1:0] CS_65536  = 2'b10;
    localparam logic [1:0] CS_16384  = 2'b11;

    localparam int unsigned TAC_EN_BIT = 2;

    localparam logic [4:0] TAC_RD_PAD = 5'b11111;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        OVF  = 2'b01,
        RELD = 2'b10
    } state_e;

    function automatic logic tap_select(input logic [3:0] taps, input logic [1:0] cs);
        logic s;
        s = 1'b0;
        case (cs)
            CS_4096:   s = taps[0];
            CS_262144: s = taps[1];
            CS_65536:  s = taps[2];
            CS_16384:  s = taps[3];
            default:   s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dmg_timer_tick.sv
// Tick generator: selects a divider tap per TAC and emits a one-cycle pulse on its falling edge.
// DMG_TIMER_TAC_GLITCH_EN selects edge detection on the gated signal (TAC writes can tick).
module dmg_timer_tick
    import dmg_timer_pkg::*;
(
    input  logic       clk,
    input  logic       nreset,
    input  logic [3:0] tap,
    input  logic [2:0] tac,
    output logic       tick
);

`ifdef DMG_TIMER_TAC_GLITCH_EN
    logic tsig;
    logic tsig_q;
    logic tsig_d;

    always_comb begin
        tsig   = tap_select(tap, tac[1:0]) & tac[TAC_EN_BIT];
        tsig_d = tsig;
        tick   = tsig_q & ~tsig;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tsig_q <= 1'b0;
        end else begin
            tsig_q <= tsig_d;
        end
    end
`else
    logic [3:0] tap_q;
    logic [3:0] tap_d;

    // Every raw tap is edge-tracked so a TAC change never manufactures a falling edge.
    always_comb begin
        tap_d = tap;
        tick  = tac[TAC_EN_BIT]
              & tap_select(tap_q, tac[1:0])
              & ~tap_select(tap, tac[1:0]);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tap_q <= '0;
        end else begin
            tap_q <= tap_d;
        end
    end
`endif

endmodule

// File: rtl/dmg_timer.sv
// DMG timer top: TIMA/TMA/TAC registers, overflow/reload FSM and CPU bus interface.
// Optional build macro: DMG_TIMER_TAC_GLITCH_EN (see dmg_timer_tick).
module dmg_timer
    import dmg_timer_pkg::*;
#(
    parameter logic [7:0] TIMA_RESET = 8'h00,
    parameter logic [7:0] TMA_RESET  = 8'h00,
    parameter logic [2:0] TAC_RESET  = 3'b000
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [3:0] tap,
    input  logic       sel_tima,
    input  logic       sel_tma,
    input  logic       sel_tac,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    inout  logic [7:0] d,
    output logic       int_timer
);

    state_e     state_q;
    state_e     state_d;
    logic [7:0] tima_q;
    logic [7:0] tima_d;
    logic [7:0] tma_q;
    logic [7:0] tma_d;
    logic [2:0] tac_q;
    logic [2:0] tac_d;

    logic       tick;
    logic       wr_tima;
    logic       wr_tma;
    logic       wr_tac;
    logic       rd_hit;
    logic [7:0] rdata;

    dmg_timer_tick u_tick (
        .clk    (clk),
        .nreset (nreset),
        .tap    (tap),
        .tac    (tac_q),
        .tick   (tick)
    );

    always_comb begin
        wr_tima = cpu_wr & sel_tima;
        wr_tma  = cpu_wr & sel_tma;
        wr_tac  = cpu_wr & sel_tac;
    end

    always_comb begin
        state_d = state_q;
        tima_d  = tima_q;
        tma_d   = tma_q;
        tac_d   = tac_q;

        if (wr_tma) begin
            tma_d = d;
        end
        if (wr_tac) begin
            tac_d = d[2:0];
        end

        // Reload uses tma_d so a TMA write landing on the reload edge passes straight through.
        case (state_q)
            RUN: begin
                if (wr_tima) begin
                    tima_d = d;
                end else if (tick) begin
                    if (tima_q == 8'hFF) begin
                        tima_d  = '0;
                        state_d = OVF;
                    end else begin
                        tima_d = tima_q + 8'd1;
                    end
                end
            end
            OVF: begin
                if (wr_tima) begin
                    tima_d  = d;
                    state_d = RUN;
                end else begin
                    tima_d  = tma_d;
                    state_d = RELD;
                end
            end
            RELD: begin
                tima_d  = tma_d;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= RUN;
            tima_q  <= TIMA_RESET;
            tma_q   <= TMA_RESET;
            tac_q   <= TAC_RESET;
        end else begin
            state_q <= state_d;
            tima_q  <= tima_d;
            tma_q   <= tma_d;
            tac_q   <= tac_d;
        end
    end

    // Decoded from state so an asynchronous reset drops the request immediately.
    always_comb begin
        int_timer = (state_q == RELD);
    end

    always_comb begin
        rdata  = '0;
        rd_hit = cpu_rd & (sel_tima | sel_tma | sel_tac);
        if (sel_tima) begin
            rdata = (state_q == OVF) ? 8'h00 : tima_q;
        end else if (sel_tma) begin
            rdata = tma_q;
        end else if (sel_tac) begin
            rdata = {TAC_RD_PAD, tac_q};
        end
    end

    assign d = rd_hit ? rdata : 8'hzz;

endmodule

// File: tb/tb_dmg_timer.sv
// Directed self-checking bench for dmg_timer: counting, overflow/reload, write races,
// TAC-write ticks, bus reads and asynchronous reset during reload.
module tb_dmg_timer;

    localparam int A_TIMA = 0;
    localparam int A_TMA  = 1;
    localparam int A_TAC  = 2;

`ifdef DMG_TIMER_TAC_GLITCH_EN
    localparam logic [7:0] GLITCH_EXP = 8'h31;
`else
    localparam logic [7:0] GLITCH_EXP = 8'h30;
`endif

    logic       clk;
    logic       nreset;
    logic [3:0] tap;
    logic       sel_tima;
    logic       sel_tma;
    logic       sel_tac;
    logic       cpu_wr;
    logic       cpu_rd;
    logic       int_timer;
    logic       tb_den;
    logic [7:0] tb_d;
    wire  [7:0] d;

    int tests = 0;
    int fails = 0;

    assign d = tb_den ? tb_d : 8'hzz;

    dmg_timer dut (
        .clk       (clk),
        .nreset    (nreset),
        .tap       (tap),
        .sel_tima  (sel_tima),
        .sel_tma   (sel_tma),
        .sel_tac   (sel_tac),
        .cpu_wr    (cpu_wr),
        .cpu_rd    (cpu_rd),
        .d         (d),
        .int_timer (int_timer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        assert ($onehot0({sel_tima, sel_tma, sel_tac}))
            else $error("FAIL sel_onehot: selects=%b required one-hot or zero", {sel_tima, sel_tma, sel_tac});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired, required completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input int which);
        sel_tima = (which == A_TIMA);
        sel_tma  = (which == A_TMA);
        sel_tac  = (which == A_TAC);
    endtask

    task automatic wr(input int which, input logic [7:0] v);
        set_sel(which);
        cpu_wr = 1'b1;
        tb_d   = v;
        tb_den = 1'b1;
        cyc();
        set_sel(-1);
        cpu_wr = 1'b0;
        tb_den = 1'b0;
    endtask

    task automatic rd(input int which, output logic [7:0] v);
        set_sel(which);
        cpu_rd = 1'b1;
        #1;
        v = d;
        cpu_rd = 1'b0;
        set_sel(-1);
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
            else begin
                fails++;
                $error("FAIL %s: got %h expected %h", tag, obs, exp);
            end
    endtask

    task automatic check_rd(input string tag, input int which, input logic [7:0] exp);
        logic [7:0] v;
        rd(which, v);
        check8(tag, v, exp);
    endtask

    task automatic check_int(input string tag, input logic exp);
        tests++;
        assert (int_timer === exp)
            else begin
                fails++;
                $error("FAIL %s: int_timer got %b expected %b", tag, int_timer, exp);
            end
    endtask

    // Two cycles high, two low; the increment lands on the third edge.
    task automatic pulse_tap(input int idx);
        tap[idx] = 1'b1;
        cyc();
        cyc();
        tap[idx] = 1'b0;
        cyc();
        cyc();
    endtask

    // Leaves the DUT right after edge N, i.e. in the OVF cycle.
    task automatic run_to_ovf();
        tap[0] = 1'b1;
        cyc();
        cyc();
        tap[0] = 1'b0;
        cyc();
    endtask

    initial begin
        nreset   = 1'b0;
        tap      = '0;
        sel_tima = 1'b0;
        sel_tma  = 1'b0;
        sel_tac  = 1'b0;
        cpu_wr   = 1'b0;
        cpu_rd   = 1'b0;
        tb_den   = 1'b0;
        tb_d     = '0;

        #12;
        check_int("reset_int", 1'b0);
        check_rd("reset_tima", A_TIMA, 8'h00);
        check_rd("reset_tma", A_TMA, 8'h00);
        check_rd("reset_tac", A_TAC, 8'hF8);
        nreset = 1'b1;
        cyc();

        // Basic count on 262144 Hz tap
        wr(A_TAC, 8'h05);
        wr(A_TIMA, 8'h00);
        pulse_tap(1);
        check_rd("count_first", A_TIMA, 8'h01);
        for (int i = 0; i < 9; i++) pulse_tap(1);
        check_rd("count_ten", A_TIMA, 8'h0A);
        check_int("count_no_int", 1'b0);

        // Overflow and reload
        wr(A_TAC, 8'h04);
        wr(A_TMA, 8'hC0);
        wr(A_TIMA, 8'hFF);
        run_to_ovf();
        check_rd("ovf_tima_zero", A_TIMA, 8'h00);
        check_int("ovf_int_low", 1'b0);
        cyc();
        check_rd("reld_tima", A_TIMA, 8'hC0);
        check_int("reld_int_high", 1'b1);
        cyc();
        check_int("after_reld_int_low", 1'b0);
        check_rd("after_reld_tima", A_TIMA, 8'hC0);

        // TIMA write in OVF cancels reload and interrupt
        wr(A_TIMA, 8'hFF);
        run_to_ovf();
        wr(A_TIMA, 8'h55);
        check_rd("cancel_tima", A_TIMA, 8'h55);
        check_int("cancel_int0", 1'b0);
        cyc();
        check_rd("cancel_tima_hold", A_TIMA, 8'h55);
        check_int("cancel_int1", 1'b0);

        // TIMA write in RELD is ignored
        wr(A_TIMA, 8'hFF);
        run_to_ovf();
        cyc();
        check_int("reld_a_int", 1'b1);
        wr(A_TIMA, 8'h11);
        check_rd("reld_tima_wr_ignored", A_TIMA, 8'hC0);
        check_int("reld_a_int_done", 1'b0);

        // TMA write in RELD writes through to TIMA
        wr(A_TIMA, 8'hFF);
        run_to_ovf();
        cyc();
        wr(A_TMA, 8'h22);
        check_rd("reld_tma_through_tima", A_TIMA, 8'h22);
        check_rd("reld_tma_through_tma", A_TMA, 8'h22);

        // TAC write disabling the timer while selected tap is high
        wr(A_TIMA, 8'h30);
        tap[3] = 1'b1;
        wr(A_TAC, 8'h07);
        cyc();
        cyc();
        check_rd("glitch_pre", A_TIMA, 8'h30);
        wr(A_TAC, 8'h03);
        cyc();
        cyc();
        check_rd("glitch_tima", A_TIMA, GLITCH_EXP);
        tap[3] = 1'b0;
        cyc();
        cyc();
        check_rd("glitch_tap_release", A_TIMA, GLITCH_EXP);

        // TIMA write on the same edge as a tick: write wins
        wr(A_TAC, 8'h05);
        wr(A_TIMA, 8'h40);
        tap[1] = 1'b1;
        cyc();
        cyc();
        tap[1] = 1'b0;
        wr(A_TIMA, 8'h77);
        check_rd("wr_beats_tick", A_TIMA, 8'h77);
        cyc();
        check_rd("wr_beats_tick_hold", A_TIMA, 8'h77);

        // Reads and bus release
        wr(A_TAC, 8'hFD);
        check_rd("tac_read", A_TAC, 8'hFD);
        check_rd("tma_read", A_TMA, 8'h22);
        // Released bus: the bench's own drive value must come back unaltered
        tb_d   = 8'h3C;
        tb_den = 1'b1;
        cpu_rd = 1'b1;
        #1;
        check8("bus_released", d, 8'h3C);
        cpu_rd = 1'b0;
        tb_den = 1'b0;

        // Asynchronous reset in RELD
        wr(A_TAC, 8'h04);
        wr(A_TIMA, 8'hFF);
        run_to_ovf();
        cyc();
        check_int("rst_pre_int", 1'b1);
        #2;
        nreset = 1'b0;
        #1;
        check_int("rst_int_async", 1'b0);
        check_rd("rst_tima", A_TIMA, 8'h00);
        check_rd("rst_tma", A_TMA, 8'h00);
        check_rd("rst_tac", A_TAC, 8'hF8);
        cyc();
        nreset = 1'b1;
        cyc();
        check_int("post_rst_int", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
